// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch state encoding,
// instruction field layout and the multiply-detect helper.
package cpu_pkg;

  localparam int          INSTR_W     = 32;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] PC_READ_OFS = 32'd8;
  localparam logic [3:0]  MUL_PATTERN = 4'b1001;
  localparam logic [1:0]  OP_DP       = 2'b00;
  localparam logic [1:0]  OP_MEM      = 2'b01;
  localparam logic [1:0]  OP_BR       = 2'b10;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    FETCH    = 2'd1,
    VALID    = 2'd2
  } fetch_state_t;

  // Multiply lives in the data-processing space: register operand form with
  // the 1001 marker in bits [7:4]; the immediate form reuses those bits.
  function automatic logic is_mul(input logic [INSTR_W-1:0] instr);
    return (instr[27:26] == OP_DP) && !instr[25] && (instr[7:4] == MUL_PATTERN);
  endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of a 32-bit instruction into the decoder's input fields.
// Shared by the fetch stage and any later pipelined decode stage.
module instr_fields
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         cond,
  output logic [1:0]         op,
  output logic [5:0]         funct,
  output logic [3:0]         rd,
  output logic               mul
);

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];
  assign mul   = is_mul(instr);

  // Operand fields are consumed by the register file, not by this split.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{instr[19:16], instr[11:8], instr[3:0]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack port, latches
// the instruction and hands its decoder fields downstream with valid/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pc_src,
  input  logic [31:0]        pc_target,
  output logic [31:0]        instr,
  output logic [3:0]         Cond,
  output logic [1:0]         Op,
  output logic [5:0]         Funct,
  output logic [3:0]         Rd,
  output logic               Mul,
  output logic [31:0]        pc_plus8,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pc_nxt;
  logic         accept;
  logic         capture;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    unique case (state)
      RST_HOLD: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = RST_HOLD;
    endcase
  end

  // Redirect targets are forced word-aligned; sequential fetch wraps mod 2^32.
  assign pc_nxt = pc_src ? {pc_target[31:2], 2'b00} : pc + PC_STEP;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_HOLD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc <= RESET_PC_ALIGNED;
    else if (accept) pc <= pc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       instr <= '0;
    else if (capture) instr <= imem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fetch_count <= '0;
    else if (accept) fetch_count <= fetch_count + CNT_W'(1);
  end

  assign imem_addr = pc;
  assign pc_plus8  = pc + PC_READ_OFS;

  instr_fields u_fields (
    .instr (instr),
    .cond  (Cond),
    .op    (Op),
    .funct (Funct),
    .rd    (Rd),
    .mul   (Mul)
  );

  // The low target bits are architecturally ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^pc_target[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: decode table, hand-written corner
// sequences, then randomized fetch/accept traffic against a PC/count model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, instr_ready, pc_src, mul;
  logic [31:0] imem_addr, imem_rdata, pc_target, instr, pc_plus8, fetch_count;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;

  // Second instance at the top of the address space for wrap-around.
  logic        w_req, w_ack, w_valid, w_ready, w_mul;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc8, w_count;
  logic [3:0]  w_cond, w_rd;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_src(pc_src), .pc_target(pc_target),
    .instr(instr), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd), .Mul(mul),
    .pc_plus8(pc_plus8), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .instr_ready(w_ready), .pc_src(1'b0), .pc_target(32'h0),
    .instr(w_instr), .Cond(w_cond), .Op(w_op), .Funct(w_funct), .Rd(w_rd),
    .Mul(w_mul), .pc_plus8(w_pc8), .fetch_count(w_count)
  );

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  exp_cond;
    logic [1:0]  exp_op;
    logic [5:0]  exp_funct;
    logic [3:0]  exp_rd;
    logic        exp_mul;
  } vec_t;

  vec_t vecs[6];

  // Reference model: architectural PC of the next fetch and accepted count.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Fields as the decoder sees them, derived from the instruction word alone.
  task automatic check_fields(input logic [31:0] d);
    logic exp_mul;
    exp_mul = (d[27:26] == 2'b00) && (d[25] == 1'b0) && (d[7:4] == 4'b1001);
    check("instr", instr, d);
    check("Cond", 32'(cond), 32'(d[31:28]));
    check("Op", 32'(op), 32'(d[27:26]));
    check("Funct", 32'(funct), 32'(d[25:20]));
    check("Rd", 32'(rd), 32'(d[15:12]));
    check("Mul", 32'(mul), 32'(exp_mul));
  endtask

  // Serve one fetch: wait (bounded) for the request, stall 'delay' cycles,
  // then ack with 'data'. Returns aligned to a negedge with instr_valid due.
  task automatic fetch(input logic [31:0] data, input int delay, input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    check("valid_in_fetch", 32'(instr_valid), 32'd0);
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      step();
      check("req_stable", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ack", 32'(instr_valid), 32'd1);
    check("req_in_valid", 32'(imem_req), 32'd0);
    check("pc_plus8", pc_plus8, exp_addr + 32'd8);
  endtask

  task automatic accept(input logic src, input logic [31:0] tgt);
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    step();
    instr_ready = 1'b0;
    pc_src      = $urandom;
    pc_target   = $urandom;
    m_pc  = src ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    check("valid_after_accept", 32'(instr_valid), 32'd0);
    check("next_addr", imem_addr, m_pc);
    check("fetch_count", fetch_count, m_cnt);
  endtask

  // Stall in VALID with spurious acks and changing read data.
  task automatic hold(input int cycles, input logic [31:0] d);
    for (int i = 0; i < cycles; i++) begin
      instr_ready = 1'b0;
      imem_ack    = $urandom;
      imem_rdata  = $urandom;
      step();
      check("hold_instr", instr, d);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_no_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    vecs[0] = '{32'hE081_0002, 0, 4'hE, 2'b00, 6'b001000, 4'h0, 1'b0};
    vecs[1] = '{32'hE000_0291, 3, 4'hE, 2'b00, 6'b000000, 4'h0, 1'b1};
    vecs[2] = '{32'hE591_2004, 1, 4'hE, 2'b01, 6'b011001, 4'h2, 1'b0};
    vecs[3] = '{32'hEA00_0010, 0, 4'hE, 2'b10, 6'b100000, 4'h0, 1'b0};
    vecs[4] = '{32'h0029_1392, 2, 4'h0, 2'b00, 6'b000010, 4'h1, 1'b1};
    vecs[5] = '{32'hE200_0090, 0, 4'hE, 2'b00, 6'b100000, 4'h0, 1'b0};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    pc_src = 1'b0; pc_target = 32'h0;
    w_ack = 1'b1; w_ready = 1'b0; w_rdata = 32'hE1A0_0000;
    m_pc = 32'h0; m_cnt = 32'h0;
    step(); step();

    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc_plus8", pc_plus8, 32'h8);
    check("rst_instr", instr, 32'h0);
    check("rst_mul", 32'(mul), 32'd0);
    check("rst_count", fetch_count, 32'h0);

    rst_n = 1'b1;
    #1;
    check("rst_hold_req", 32'(imem_req), 32'd0);
    step();

    // Decode table, sequential fetch with varied memory latency.
    foreach (vecs[i]) begin
      fetch(vecs[i].rdata, vecs[i].delay, m_pc);
      check("tbl_Cond", 32'(cond), 32'(vecs[i].exp_cond));
      check("tbl_Op", 32'(op), 32'(vecs[i].exp_op));
      check("tbl_Funct", 32'(funct), 32'(vecs[i].exp_funct));
      check("tbl_Rd", 32'(rd), 32'(vecs[i].exp_rd));
      check("tbl_Mul", 32'(mul), 32'(vecs[i].exp_mul));
      accept(1'b0, $urandom);
    end

    // Redirect with unaligned target.
    fetch(32'hE1A0_F00E, 0, m_pc);
    accept(1'b1, 32'h0000_0103);
    check("redirect_addr", imem_addr, 32'h0000_0100);

    // Stall in VALID, then redirect to 0x40.
    fetch(32'hE3A0_1005, 1, m_pc);
    hold(5, 32'hE3A0_1005);
    accept(1'b1, 32'h0000_0040);

    // Reset lands mid-fetch with an ack in the same cycle.
    check("pre_rst_addr", imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_count", fetch_count, 32'h0);
    check("midrst_pc_plus8", pc_plus8, 32'h8);
    step();
    rst_n = 1'b1;
    #1;
    check("midrst_hold_req", 32'(imem_req), 32'd0);
    check("midrst_ack_dropped", instr, 32'h0);
    step();
    imem_ack = 1'b0;
    check("midrst_still_empty", instr, 32'h0);
    m_pc = 32'h0; m_cnt = 32'h0;
    fetch(32'hE081_0002, 0, m_pc);
    check_fields(32'hE081_0002);
    accept(1'b0, 32'h0);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      d = $urandom;
      fetch(d, $urandom_range(0, 3), m_pc);
      check_fields(d);
      hold($urandom_range(0, 3), d);
      accept(($urandom_range(0, 3) == 0), $urandom);
    end

    // Wrap-around instance: reset at 0xFFFFFFFC, zero-wait memory, no redirect.
    rst_n = 1'b0;
    #1;
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap_rst_pc8", w_pc8, 32'h0000_0004);
    check("wrap_rst_req", 32'(w_req), 32'd0);
    check("wrap_rst_valid", 32'(w_valid), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("wrap_hold_req", 32'(w_req), 32'd0);
    step();
    check("wrap_fetch_req", 32'(w_req), 32'd1);
    check("wrap_fetch_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_valid", 32'(w_valid), 32'd1);
    check("wrap_instr", w_instr, 32'hE1A0_0000);
    check("wrap_pc8", w_pc8, 32'h0000_0004);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    check("wrap_next_addr", w_addr, 32'h0000_0000);
    check("wrap_count", w_count, 32'h1);
    check("wrap_req_again", 32'(w_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
